// File: rtl/fifo_32_to_8.sv
// Width-converting FIFO: 32-bit words in, 8-bit bytes out (LS byte first), first-word-fall-through.
// Latency: a word written at edge N reaches the unpack stage at edge N+1; EMPTY falls after N+1.
// Backpressure: FULL drops writes (pre-edge FULL); READ while EMPTY is ignored; no bubble across words.
module fifo_32_to_8 #(
    parameter int DEPTH = 1024
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WRITE,
    input  logic [31:0]                DATA_IN,
    output logic                       FULL,
    input  logic                       READ,
    output logic                       EMPTY,
    output logic [7:0]                 DATA_OUT,
    output logic [$clog2(DEPTH)+2:0]   SIZE
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          full_q;

    logic [31:0]   word_reg;
    logic [1:0]    byte_idx;
    logic          valid;

    logic          push;
    logic          pop;
    logic          rd_ok;
    logic          load;
    logic          buf_empty;
    logic [2:0]    unpack_bytes;

    assign push      = WRITE && !full_q;
    assign rd_ok     = READ && valid;
    assign buf_empty = (count == '0);
    // Reload the unpack stage when idle or as its last byte is consumed, so streaming has no bubble.
    assign load      = !valid || (rd_ok && byte_idx == 2'd3);
    assign pop       = load && !buf_empty;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count  <= count_nxt;
            full_q <= (count_nxt == CNT_FULL);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word_reg <= '0;
            byte_idx <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            byte_idx <= '0;
            if (!buf_empty) begin
                word_reg <= mem[rd_ptr];
                valid    <= 1'b1;
            end else begin
                valid    <= 1'b0;
            end
        end else if (rd_ok) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    always_comb begin
        DATA_OUT = word_reg[7:0];
        case (byte_idx)
            2'd0:    DATA_OUT = word_reg[7:0];
            2'd1:    DATA_OUT = word_reg[15:8];
            2'd2:    DATA_OUT = word_reg[23:16];
            default: DATA_OUT = word_reg[31:24];
        endcase
    end

    assign unpack_bytes = valid ? (3'd4 - {1'b0, byte_idx}) : 3'd0;

    assign FULL  = full_q;
    assign EMPTY = !valid;
    assign SIZE  = {count, 2'b00} + {{AW{1'b0}}, unpack_bytes};

endmodule

// File: doc/fifo_32_to_8.md
Name: fifo_32_to_8

Overview:
- Width-converting FIFO that accepts 32-bit words and delivers them as a stream of 8-bit bytes.
- Least-significant byte of each word is delivered first.
- Sits between a 32-bit word source (bus-side FIFO read port, BRAM FIFO output) and a byte-wide consumer (serializer, byte sync FIFO, UART/SPI transmitter).
- Mirror of the 8-to-32 packing FIFO: output is first-word-fall-through, so byte data is valid whenever EMPTY is low.

Parameters:
- DEPTH, 1024, number of 32-bit words in the internal circular buffer; must be a power of two, minimum 2.

Ports:
- CLK  input  1  single clock for all logic.
- RST  input  1  asynchronous, active-high reset.
- WRITE  input  1  write strobe; DATA_IN is stored on the rising edge when WRITE=1 and FULL=0.
- DATA_IN  input  32  word to write; byte 0 = DATA_IN[7:0].
- FULL  output  1  internal word buffer holds DEPTH words.
- READ  input  1  consume the current output byte; honoured only when EMPTY=0.
- EMPTY  output  1  no byte available; DATA_OUT is invalid while EMPTY=1.
- DATA_OUT  output  8  current byte, valid while EMPTY=0.
- SIZE  output  $clog2(DEPTH)+3  bytes held: 4 × buffered words + bytes remaining in the unpack register.

Behaviour:
- Storage:
  - Word buffer: DEPTH-entry circular memory with write pointer, read pointer and word count.
  - Pointers wrap modulo DEPTH.
  - FULL = (word count == DEPTH), registered.
- Unpack stage:
  - State: 32-bit word_reg, 2-bit byte_idx and a valid flag.
  - EMPTY = !valid.
  - DATA_OUT = word_reg[8*byte_idx +: 8].
- Load rule: on a clock edge, if (!valid) or (READ && valid && byte_idx==3):
  - word buffer not empty → load the head word into word_reg, byte_idx=0, valid=1, pop the buffer.
  - word buffer empty → valid=0.
- Read rule: READ && valid && byte_idx<3 → byte_idx+1.
- Ignored strobes:
  - READ while EMPTY=1 has no effect.
  - WRITE while FULL=1 drops the word with no state change.
  - FULL is evaluated on its pre-edge value, so a pop in the same cycle does not admit the write.
- Simultaneous push and pop in one cycle is legal; word count is unchanged.
- Latency:
  - WRITE sampled at edge N into an empty block → word in buffer after edge N.
  - Same word loaded into the unpack stage at edge N+1; EMPTY falls after edge N+1.
- Throughput: READ held high with the buffer non-empty yields one byte per cycle with no bubble at word boundaries.
- Capacity: DEPTH+1 words in total (DEPTH in the buffer plus one in the unpack stage).
- SIZE updates every cycle:
  - +4 per accepted write.
  - −1 per honoured READ.
  - e.g. accepted write + honoured READ in the same cycle → +3.
- Reset (asynchronous, any time, including mid-word):
  - Pointers and count = 0; valid = 0; byte_idx = 0; word_reg = 0.
  - Outputs: EMPTY=1, FULL=0, SIZE=0, DATA_OUT=0x00.
  - All buffered data is discarded.
  - Memory contents need not be cleared.

Test Plan:
- Reset: assert RST without a clock edge → EMPTY=1, FULL=0, SIZE=0, DATA_OUT=0x00 immediately.
- Single word: write 0x44332211, then READ=1 for 4 cycles.
  - EMPTY low after the 2nd edge following the write.
  - DATA_OUT = 0x11, 0x22, 0x33, 0x44.
  - SIZE = 4, 3, 2, 1, then 0 with EMPTY=1.
- Streaming: write 0x03020100, 0x07060504, 0x0B0A0908 back-to-back with READ held high → bytes 0x00..0x0B in order with no gaps; EMPTY=1 afterwards.
- Full (DEPTH=4): 6 back-to-back writes of words W0..W5, no reads.
  - FULL rises after the 5th edge; W5 is dropped; SIZE=20.
  - Draining yields the 20 bytes of W0..W4 only.
  - FULL falls after the first pop from the buffer, i.e. when W1 is loaded.
- Concurrent: with SIZE=8, one cycle of WRITE=1 and READ=1 → SIZE=11; byte order preserved.
- Reset mid-stream: after 2 of 4 bytes have been read, pulse RST asynchronously.
  - EMPTY=1 and SIZE=0 at once.
  - Then write 0xDDCCBBAA → 0xAA, 0xBB, 0xCC, 0xDD with no stale bytes.
